// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: owns the PC, fetches one word per cycle into a small
// queue, and hands instructions to decode over valid/ready with redirect flush.
module ifetch_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-2:0] imem_addr_out,
    input  logic [WIDTH-1:0] imem_data_in,
    input  logic             redirect_valid_in,
    input  logic [WIDTH-1:0] redirect_pc_in,
    output logic             inst_valid_out,
    input  logic             inst_ready_in,
    output logic [WIDTH-1:0] inst_out,
    output logic [WIDTH-1:0] inst_pc_out,
    output logic             fetch_misaligned_out
);

    localparam int unsigned        PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned        CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0]   ONE_PTR  = PTR_W'(1);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    entry_t           mem_q [FIFO_DEPTH];
    entry_t           head_q, head_d;
    entry_t           new_entry;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             halted_q, halted_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    assign new_entry            = {pc_q, imem_data_in};
    assign imem_addr_out        = {1'b0, pc_q[WIDTH-1:2]};
    assign inst_valid_out       = (count_q != '0) & ~redirect_valid_in;
    assign pop                  = inst_valid_out & inst_ready_in;
    assign push                 = ~halted_q & ~redirect_valid_in & ((count_q != FULL_CNT) | pop);
    assign inst_out             = head_q.instr;
    assign inst_pc_out          = head_q.pc;
    assign fetch_misaligned_out = halted_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        pc_d     = pc_q;
        halted_d = halted_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (redirect_valid_in) begin
            pc_d     = {redirect_pc_in[WIDTH-1:2], 2'b00};
            halted_d = |redirect_pc_in[1:0];
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + WIDTH'(4);
                wr_ptr_d = wr_ptr_q + ONE_PTR;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ONE_PTR;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
            // The head register holds its last value whenever the queue drains empty.
            if (count_d != '0) begin
                if ((count_q == '0) | ((count_q == ONE_CNT) & pop)) begin
                    head_d = new_entry;
                end else begin
                    head_d = mem_q[rd_ptr_d];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // NOTE: queue storage is not reset; the count and head register alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus random traffic
// compared against a queue-based reference model of the fetch rules.
module tb_ifetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] SALT  = 32'h5A3C_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [30:0] imem_addr_out;
    logic [31:0] imem_data_in;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        inst_valid_out;
    logic        inst_ready_in;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic        fetch_misaligned_out;

    logic [30:0] w_addr;
    logic [31:0] w_data;
    logic        w_rv, w_rdy, w_valid, w_mis;
    logic [31:0] w_rpc, w_inst, w_pc;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic        m_halted;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];

    always #5 clk = ~clk;

    assign imem_data_in = ({1'b0, imem_addr_out} << 2) ^ SALT;
    assign w_data       = ({1'b0, w_addr} << 2) ^ SALT;

    ifetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_addr_out(imem_addr_out), .imem_data_in(imem_data_in),
        .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
        .inst_valid_out(inst_valid_out), .inst_ready_in(inst_ready_in),
        .inst_out(inst_out), .inst_pc_out(inst_pc_out),
        .fetch_misaligned_out(fetch_misaligned_out)
    );

    ifetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst(rst),
        .imem_addr_out(w_addr), .imem_data_in(w_data),
        .redirect_valid_in(w_rv), .redirect_pc_in(w_rpc),
        .inst_valid_out(w_valid), .inst_ready_in(w_rdy),
        .inst_out(w_inst), .inst_pc_out(w_pc),
        .fetch_misaligned_out(w_mis)
    );

    task automatic model_reset(input logic [31:0] rpc);
        m_pc     = rpc;
        m_halted = 1'b0;
        q_pc.delete();
        q_inst.delete();
    endtask

    // One clock cycle: drive inputs, compare against the model mid-cycle, then advance the model at the edge.
    task automatic run_cycle(input logic rv, input logic [31:0] rpc, input logic rdy,
                             output logic acc, output logic [31:0] acc_pc);
        logic        exp_valid, do_pop, do_push;
        logic [30:0] exp_addr;
        redirect_valid_in = rv;
        redirect_pc_in    = rpc;
        inst_ready_in     = rdy;
        @(negedge clk);
        exp_valid = (q_pc.size() != 0) && !rv;
        exp_addr  = m_pc[31:2];
        n_assert++;
        if (inst_valid_out !== exp_valid) begin
            n_fail++;
            $display("FAIL cyc_valid: got %b expected %b at %0t", inst_valid_out, exp_valid, $time);
        end
        n_assert++;
        if (imem_addr_out !== exp_addr) begin
            n_fail++;
            $display("FAIL cyc_addr: got %h expected %h at %0t", imem_addr_out, exp_addr, $time);
        end
        n_assert++;
        if (fetch_misaligned_out !== m_halted) begin
            n_fail++;
            $display("FAIL cyc_misaligned: got %b expected %b at %0t", fetch_misaligned_out, m_halted, $time);
        end
        if (q_pc.size() != 0) begin
            n_assert++;
            if (inst_pc_out !== q_pc[0]) begin
                n_fail++;
                $display("FAIL cyc_inst_pc: got %h expected %h at %0t", inst_pc_out, q_pc[0], $time);
            end
            n_assert++;
            if (inst_out !== q_inst[0]) begin
                n_fail++;
                $display("FAIL cyc_inst: got %h expected %h at %0t", inst_out, q_inst[0], $time);
            end
        end
        acc    = inst_valid_out & rdy;
        acc_pc = inst_pc_out;
        @(posedge clk);
        do_pop  = exp_valid && rdy;
        do_push = !m_halted && !rv && (q_pc.size() < DEPTH || do_pop);
        if (rv) begin
            q_pc.delete();
            q_inst.delete();
            m_pc     = rpc & ~32'h3;
            m_halted = (rpc[1:0] != 2'b00);
        end else begin
            if (do_pop) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (do_push) begin
                q_pc.push_back(m_pc);
                q_inst.push_back(m_pc ^ SALT);
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset(32'h0);
    endtask

    task automatic test_reset();
        logic        acc;
        logic [31:0] apc;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if (inst_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", inst_valid_out); end
        n_assert++;
        if (inst_out !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h expected 0", inst_out); end
        n_assert++;
        if (inst_pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc_out); end
        n_assert++;
        if (imem_addr_out !== 31'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", imem_addr_out); end
        n_assert++;
        if (fetch_misaligned_out !== 1'b0) begin n_fail++; $display("FAIL rst_misaligned: got %b expected 0", fetch_misaligned_out); end
        rst = 1'b0;
        model_reset(32'h0);
        run_cycle(1'b0, 32'h0, 1'b1, acc, apc);
        n_assert++;
        if (inst_valid_out !== 1'b1 || inst_pc_out !== 32'h0) begin
            n_fail++;
            $display("FAIL first_valid: got valid=%b pc=%h expected valid=1 pc=0", inst_valid_out, inst_pc_out);
        end
    endtask

    task automatic test_stream();
        logic        acc;
        logic [31:0] apc;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1, acc, apc);
            n_assert++;
            if (acc !== 1'b1 || apc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_seq: got acc=%b pc=%h expected acc=1 pc=%h", acc, apc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        logic        acc;
        logic [31:0] apc;
        apply_reset();
        repeat (6) run_cycle(1'b0, 32'h0, 1'b0, acc, apc);
        n_assert++;
        if (imem_addr_out !== 31'd2) begin n_fail++; $display("FAIL bp_addr_hold: got %h expected 2", imem_addr_out); end
        n_assert++;
        if (inst_valid_out !== 1'b1 || inst_pc_out !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_head_hold: got valid=%b pc=%h expected valid=1 pc=0", inst_valid_out, inst_pc_out);
        end
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1, acc, apc);
            n_assert++;
            if (acc !== 1'b1 || apc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL bp_drain: got acc=%b pc=%h expected acc=1 pc=%h", acc, apc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        logic        acc;
        logic [31:0] apc;
        apply_reset();
        repeat (3) run_cycle(1'b0, 32'h0, 1'b0, acc, apc);
        run_cycle(1'b1, 32'h100, 1'b1, acc, apc);
        n_assert++;
        if (acc !== 1'b0) begin n_fail++; $display("FAIL redir_no_consume: got acc=%b expected 0", acc); end
        n_assert++;
        if (imem_addr_out !== 31'h40 || inst_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_addr: got addr=%h valid=%b expected addr=40 valid=0", imem_addr_out, inst_valid_out);
        end
        run_cycle(1'b0, 32'h0, 1'b1, acc, apc);
        n_assert++;
        if (inst_valid_out !== 1'b1 || inst_pc_out !== 32'h100 || inst_out !== (32'h100 ^ SALT)) begin
            n_fail++;
            $display("FAIL redir_first: got valid=%b pc=%h inst=%h expected valid=1 pc=100 inst=%h",
                     inst_valid_out, inst_pc_out, inst_out, 32'h100 ^ SALT);
        end
    endtask

    task automatic test_misaligned();
        logic        acc;
        logic [31:0] apc;
        run_cycle(1'b1, 32'h102, 1'b1, acc, apc);
        n_assert++;
        if (fetch_misaligned_out !== 1'b1 || imem_addr_out !== 31'h40) begin
            n_fail++;
            $display("FAIL mis_set: got flag=%b addr=%h expected flag=1 addr=40", fetch_misaligned_out, imem_addr_out);
        end
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1, acc, apc);
            n_assert++;
            if (acc !== 1'b0 || imem_addr_out !== 31'h40) begin
                n_fail++;
                $display("FAIL mis_halted: got acc=%b addr=%h expected acc=0 addr=40", acc, imem_addr_out);
            end
        end
        run_cycle(1'b1, 32'h200, 1'b1, acc, apc);
        n_assert++;
        if (fetch_misaligned_out !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b expected 0", fetch_misaligned_out); end
        run_cycle(1'b0, 32'h0, 1'b1, acc, apc);
        n_assert++;
        if (inst_valid_out !== 1'b1 || inst_pc_out !== 32'h200) begin
            n_fail++;
            $display("FAIL mis_resume: got valid=%b pc=%h expected valid=1 pc=200", inst_valid_out, inst_pc_out);
        end
    endtask

    task automatic test_wrap();
        logic        acc;
        logic [31:0] apc;
        logic [31:0] exp_pc[4];
        exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1, acc, apc);
            n_assert++;
            if (w_valid !== 1'b1 || w_pc !== exp_pc[i] || w_inst !== (exp_pc[i] ^ SALT)) begin
                n_fail++;
                $display("FAIL wrap_seq: got valid=%b pc=%h inst=%h expected valid=1 pc=%h inst=%h",
                         w_valid, w_pc, w_inst, exp_pc[i], exp_pc[i] ^ SALT);
            end
        end
    endtask

    task automatic test_async_reset();
        logic        acc;
        logic [31:0] apc;
        apply_reset();
        run_cycle(1'b1, 32'h38, 1'b0, acc, apc);
        repeat (3) run_cycle(1'b0, 32'h0, 1'b0, acc, apc);
        n_assert++;
        if (imem_addr_out !== 31'h10 || inst_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got addr=%h valid=%b expected addr=10 valid=1", imem_addr_out, inst_valid_out);
        end
        #2;
        rst = 1'b1;
        #1;
        n_assert++;
        if (inst_valid_out !== 1'b0 || inst_out !== 32'h0 || inst_pc_out !== 32'h0 ||
            imem_addr_out !== 31'h0 || fetch_misaligned_out !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_clear: got valid=%b inst=%h pc=%h addr=%h mis=%b expected all 0",
                     inst_valid_out, inst_out, inst_pc_out, imem_addr_out, fetch_misaligned_out);
        end
        rst = 1'b0;
        model_reset(32'h0);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1, acc, apc);
            if (i > 0) begin
                n_assert++;
                if (acc !== 1'b1 || apc !== 32'(4 * (i - 1))) begin
                    n_fail++;
                    $display("FAIL arst_restart: got acc=%b pc=%h expected acc=1 pc=%h", acc, apc, 32'(4 * (i - 1)));
                end
            end
        end
    endtask

    task automatic test_random();
        logic        acc, rv, rdy;
        logic [31:0] apc, rpc;
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       rpc = $urandom & ~32'h3;
                1:       rpc = $urandom;
                2:       rpc = 32'hFFFF_FFF0;
                default: rpc = 32'($urandom_range(0, 255)) << 2;
            endcase
            run_cycle(rv, rpc, rdy, acc, apc);
        end
    endtask

    initial begin
        rst               = 1'b1;
        redirect_valid_in = 1'b0;
        redirect_pc_in    = 32'h0;
        inst_ready_in     = 1'b0;
        w_rv              = 1'b0;
        w_rpc             = 32'h0;
        w_rdy             = 1'b1;
        model_reset(32'h0);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
